// File: rtl/fifo_level.sv
// fifo_level: synchronous FWFT FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags.
module fifo_level #(
  parameter int unsigned B        = 8,
  parameter int unsigned W        = 4,
  parameter int unsigned AF_LEVEL = 2**W - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow
);

  localparam int unsigned D  = 2**W;
  localparam int unsigned LW = W + 1;

  // Threshold sanity: almost_empty must sit strictly below almost_full,
  // and almost_full must be reachable.
  if ((AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > D)) begin : g_bad_thresholds
    $error("fifo_level: thresholds require AE_LEVEL < AF_LEVEL <= 2**W");
  end

  logic [B-1:0]  mem [D];
  logic [W-1:0]  w_ptr;
  logic [W-1:0]  r_ptr;

  logic          wr_acc;
  logic          rd_acc;
  logic [LW-1:0] level_nxt;

  // Accept decisions and next occupancy, all from the pre-edge state.
  // A write into a full FIFO is allowed when a pop frees the slot the same edge.
  always_comb begin
    wr_acc    = wr & (~full | rd);
    rd_acc    = rd & ~empty;
    level_nxt = level + LW'(wr_acc) - LW'(rd_acc);
  end

  // Pointers, level, registered flags and sticky errors; reset beats clr.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      level        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + W'(1);
      if (rd_acc) r_ptr <= r_ptr + W'(1);
      level        <= level_nxt;
      empty        <= (level_nxt == LW'(0));
      full         <= (level_nxt == LW'(D));
      almost_empty <= (level_nxt <= LW'(AE_LEVEL));
      almost_full  <= (level_nxt >= LW'(AF_LEVEL));
      overflow     <= overflow  | (wr & full & ~rd);
      underflow    <= underflow | (rd & empty);
    end
  end

  // Storage write; contents survive reset/flush but no write lands that cycle.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset && !clr) begin
      mem[w_ptr] <= w_data;
    end
  end

  // First-word-fall-through: head word is a combinational read.
  assign r_data = mem[r_ptr];

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed self-checking bench for fifo_level (B=8, W=4).
module tb_fifo_level;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;
  logic       underflow;

  int tests_run = 0;
  int tests_failed = 0;

  fifo_level #(.B(8), .W(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr = w; rd = r; clr = c; w_data = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; clr = 1'b0; w_data = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (level !== 5'd0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", level); end
    tests_run++;
    if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
      tests_failed++; $display("FAIL reset_flags got e/f/ae/af=%b exp 1010", {empty, full, almost_empty, almost_full});
    end
    tests_run++;
    if ({overflow, underflow} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_errs got ov/uf=%b exp 00", {overflow, underflow});
    end
  endtask

  // Fill with 0x00..0x0F, then one write too many.
  task automatic test_fill();
    logic [4:0] el;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(i));
      el = 5'(i + 1);
      tests_run++;
      if (level !== el) begin tests_failed++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, level, el); end
      tests_run++;
      if ({empty, full, almost_empty, almost_full} !== {1'b0, el == 5'd16, el <= 5'd2, el >= 5'd14}) begin
        tests_failed++;
        $display("FAIL fill_flags[%0d] got e/f/ae/af=%b exp %b", i, {empty, full, almost_empty, almost_full},
                 {1'b0, el == 5'd16, el <= 5'd2, el >= 5'd14});
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 8'hFF);
    tests_run++;
    if ({overflow, full, level} !== {1'b1, 1'b1, 5'd16}) begin
      tests_failed++; $display("FAIL fill_overflow got ov=%b full=%b level=%0d exp 1 1 16", overflow, full, level);
    end
    tests_run++;
    if (r_data !== 8'h00) begin tests_failed++; $display("FAIL fill_head got %h exp 00", r_data); end
  endtask

  // Drain the 16 words, then one read too many.
  task automatic test_drain();
    logic [4:0] el;
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (r_data !== 8'(i)) begin tests_failed++; $display("FAIL drain_data[%0d] got %h exp %h", i, r_data, 8'(i)); end
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      el = 5'(15 - i);
      tests_run++;
      if ({level, empty, almost_empty, full} !== {el, el == 5'd0, el <= 5'd2, 1'b0}) begin
        tests_failed++;
        $display("FAIL drain_state[%0d] got level=%0d e=%b ae=%b f=%b exp level=%0d", i, level, empty, almost_empty, full, el);
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    tests_run++;
    if ({underflow, level, overflow} !== {1'b1, 5'd0, 1'b1}) begin
      tests_failed++; $display("FAIL drain_underflow got uf=%b level=%0d ov=%b exp 1 0 1", underflow, level, overflow);
    end
  endtask

  task automatic test_latency();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    tests_run++;
    if ({empty, level, r_data} !== {1'b0, 5'd1, 8'hA5}) begin
      tests_failed++; $display("FAIL latency got e=%b level=%0d data=%h exp 0 1 a5", empty, level, r_data);
    end
  endtask

  task automatic test_simultaneous();
    // Empty: write wins, read flagged as underflow.
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 8'h11);
    tests_run++;
    if ({level, underflow, r_data} !== {5'd1, 1'b1, 8'h11}) begin
      tests_failed++; $display("FAIL simul_empty got level=%0d uf=%b data=%h exp 1 1 11", level, underflow, r_data);
    end
    // Full: pop head, append at tail, stay full.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    cyc(1'b1, 1'b1, 1'b0, 8'h55);
    tests_run++;
    if ({level, full, overflow, r_data} !== {5'd16, 1'b1, 1'b0, 8'h21}) begin
      tests_failed++;
      $display("FAIL simul_full got level=%0d f=%b ov=%b data=%h exp 16 1 0 21", level, full, overflow, r_data);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] ed;
      ed = (i == 15) ? 8'h55 : 8'(8'h21 + i);
      tests_run++;
      if (r_data !== ed) begin tests_failed++; $display("FAIL simul_full_order[%0d] got %h exp %h", i, r_data, ed); end
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
    end
    // Mid-level: level holds at 5 and order is preserved.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    cyc(1'b1, 1'b1, 1'b0, 8'h45);
    cyc(1'b1, 1'b1, 1'b0, 8'h46);
    tests_run++;
    if ({level, r_data} !== {5'd5, 8'h42}) begin
      tests_failed++; $display("FAIL simul_mid got level=%0d data=%h exp 5 42", level, r_data);
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (r_data !== 8'(8'h42 + i)) begin
        tests_failed++; $display("FAIL simul_mid_order[%0d] got %h exp %h", i, r_data, 8'(8'h42 + i));
      end
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
    end
  endtask

  // Bursts of 3 writes / 2 reads; level creeps up so pointers wrap.
  task automatic test_wrap();
    int ref_level;
    int next_in;
    int next_out;
    logic w;
    do_reset();
    ref_level = 0; next_in = 0; next_out = 0;
    for (int c = 0; c < 40; c++) begin
      w = ((c % 5) < 3);
      if (w) begin
        cyc(1'b1, 1'b0, 1'b0, 8'(next_in));
        next_in++;
        ref_level++;
      end else begin
        tests_run++;
        if (r_data !== 8'(next_out)) begin
          tests_failed++; $display("FAIL wrap_data[c=%0d] got %h exp %h", c, r_data, 8'(next_out));
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        next_out++;
        ref_level--;
      end
      tests_run++;
      if (level !== 5'(ref_level)) begin
        tests_failed++; $display("FAIL wrap_level[c=%0d] got %0d exp %0d", c, level, ref_level);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    tests_run++;
    if ({level, overflow} !== {5'd7, 1'b1}) begin
      tests_failed++; $display("FAIL flush_pre got level=%0d ov=%b exp 7 1", level, overflow);
    end
    // Flush with a concurrent write: the write must be dropped.
    cyc(1'b1, 1'b0, 1'b1, 8'h99);
    tests_run++;
    if ({level, empty, full, almost_empty, almost_full, overflow, underflow} !== {5'd0, 6'b101000}) begin
      tests_failed++;
      $display("FAIL flush_state got level=%0d e=%b f=%b ae=%b af=%b ov=%b uf=%b exp 0 1 0 1 0 0 0",
               level, empty, full, almost_empty, almost_full, overflow, underflow);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h3C);
    tests_run++;
    if ({level, r_data} !== {5'd1, 8'h3C}) begin
      tests_failed++; $display("FAIL flush_readback got level=%0d data=%h exp 1 3c", level, r_data);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; w_data = 8'h00;
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_simultaneous();
    test_wrap();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
Name: fifo_level

Overview:
- Parametrised synchronous FIFO for the UART and host-link datapaths.
- Successor of the basic pointer FIFO, adding:
  - an occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - a synchronous flush;
  - sticky overflow and underflow error flags;
  - fully defined simultaneous read/write behaviour at the full and empty boundaries.
- Read side is first-word-fall-through: the head word is always present on r_data while not empty.

Parameters:
- B, 8, data word width in bits.
- W, 4, address bits; depth D = 2**W.
- AF_LEVEL, 2**W-2, almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset.
- clr  in  1  synchronous flush; empties the FIFO and clears the error flags.
- wr  in  1  write request.
- w_data  in  B  write data, sampled at the edge where the write is accepted.
- rd  in  1  read request; pops the head word.
- r_data  out  B  head word (FWFT); undefined/don't-care while empty.
- empty  out  1  level == 0.
- full  out  1  level == D.
- almost_empty  out  1  level <= AE_LEVEL.
- almost_full  out  1  level >= AF_LEVEL.
- level  out  W+1  current occupancy, 0..D.
- overflow  out  1  sticky: a write was attempted while full and not accepted.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:

Reset and flush
- reset (highest priority) and clr (next priority) both force:
  - w_ptr = 0, r_ptr = 0, level = 0;
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0;
  - overflow = 0, underflow = 0.
- Array contents are not cleared.
- A reset or clr asserted mid-stream discards all stored words that cycle; any wr/rd in the same cycle is ignored.

Accept rules (evaluated on the pre-edge state)
- wr_acc = wr & (~full | rd).
- rd_acc = rd & ~empty.
- {wr, rd} = 11 while empty: write accepted, read ignored, underflow set; level goes to 1.
- {wr, rd} = 11 while full: both accepted; level stays D, full stays 1.
- {wr, rd} = 11 otherwise: both accepted; level unchanged.

Pointer, level and storage updates
- wr_acc: array[w_ptr] <= w_data; w_ptr <= w_ptr + 1, wrapping modulo D.
- rd_acc: r_ptr <= r_ptr + 1, wrapping modulo D.
- level <= level + wr_acc - rd_acc.
- All flags are registered and computed from the next-state level, so flags and level are mutually consistent on every cycle.

Error flags
- overflow is set on wr & full & ~rd.
- underflow is set on rd & empty.
- Both hold until reset or clr.

Latency
- Write-to-read: a word written at edge N into an empty FIFO appears on r_data and deasserts empty after edge N (one cycle).
- Read-to-next-word: after a rd_acc edge, r_data shows the next word in the same cycle; it is a combinational read of array[r_ptr].

Implementation constraints
- Pointer wrap at D-1 -> 0 must be seamless; level, not pointer equality, decides full/empty.
- Threshold parameters must satisfy 0 <= AE_LEVEL < AF_LEVEL <= D. Violation is a elaboration-time error; use a generate-time check.

Test Plan:
- Reset, then write 16 words 0x00..0x0F with no reads (W=4) -> level steps 1..16; almost_full asserts the cycle level reaches 14; full=1 at 16; a 17th write sets overflow=1 and leaves level=16 and array contents unchanged.
- From full, read 16 words -> r_data sequence 0x00..0x0F in order; almost_empty asserts at level 2; empty=1 after the last read; one extra rd sets underflow=1 and level stays 0.
- Write 0xA5 into empty FIFO at edge N -> empty=0, level=1 and r_data=0xA5 in the cycle after edge N.
- Simultaneous wr=rd=1:
  - when empty -> level 0->1, underflow=1;
  - when full -> level stays 16, oldest word popped and new word appended at the tail;
  - at level 5 -> level stays 5, data order preserved.
- Wrap-around: 40 cycles of alternating bursts of 3 writes and 2 reads with incrementing data -> the output stream is strictly incrementing with no gaps across pointer wraps, and level matches the reference count every cycle.
- Flush: assert clr at level 7 with overflow=1 -> next cycle level=0, empty=1, overflow=0; a subsequent write of 0x3C reads back as 0x3C, with no stale data.
